// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_resp memory responder.
package mem_resp_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Kind of request captured at acceptance
  typedef enum logic [1:0] {
    K_RD  = 2'd0,
    K_WR  = 2'd1,
    K_BAD = 2'd2
  } kind_e;

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with byte-enable write and registered read.
// Contents are never reset.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [STRB_W-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we_i && be_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Memory responder: accepts one read/write request at a time from the
// pipeline memory stage and answers with a single-cycle ack.
// Optional macro MEM_RESP_WAIT_EN inserts WAIT wait-state cycles before
// the response; without it the response always follows acceptance by
// one cycle.
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memrq,
  input  logic                     memwq,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [STRB_W-1:0]        wstrb,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ack,
  output logic                     busy,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);

  state_e              state_q, state_d;
  kind_e               kind_q;
  logic                rst_q;
  logic [AW-1:0]       addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                accept;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DATA_W-1:0]   ram_rdata;

`ifdef MEM_RESP_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`else
  // WAIT only matters when wait states are compiled in
  logic unused_wait;
  assign unused_wait = (WAIT != 0);
`endif

  // The cycle right after reset releases never accepts a request
  assign accept = (state_q == ST_IDLE) && (memrq || memwq) && !rst_q;

  // Control state: FSM, request kind, post-reset guard, wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      kind_q  <= K_RD;
      rst_q   <= 1'b1;
`ifdef MEM_RESP_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
`ifdef MEM_RESP_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        kind_q <= (memrq && memwq) ? K_BAD : (memwq ? K_WR : K_RD);
      end
    end
  end

  // Request payload captured at acceptance; needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  // Next-state logic: IDLE -> [WAIT] -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
`ifdef MEM_RESP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef MEM_RESP_WAIT_EN
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT - 1);
          end else begin
            state_d = ST_RESP;
          end
`else
          state_d = ST_RESP;
`endif
        end
      end
      ST_WAIT: begin
`ifdef MEM_RESP_WAIT_EN
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // In IDLE the RAM reads the incoming address so the word is ready in
  // RESP with no wait states; afterwards it keeps reading the latched one.
  assign ram_addr = (state_q == ST_IDLE) ? addr : addr_q;
  // Write commits on the edge that ends RESP; a reset in RESP drops it
  assign ram_we   = (state_q == ST_RESP) && (kind_q == K_WR) && !rst;

  mem_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (wstrb_q),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Outputs are forced quiet while reset is asserted
  assign ack   = (state_q == ST_RESP) && !rst;
  assign busy  = (state_q != ST_IDLE) && !rst;
  assign err   = ack && (kind_q == K_BAD);
  assign rdata = (ack && (kind_q == K_RD)) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: table of transactions checked through
// a response scoreboard, plus reset-abort, busy-ignore and held-request
// sequences. Works with or without MEM_RESP_WAIT_EN.
module tb_mem_resp;

  localparam int WAIT_P = 2;
`ifdef MEM_RESP_WAIT_EN
  localparam int L = (WAIT_P > 0) ? WAIT_P + 1 : 1;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memrq, memwq;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack, busy, err;

  mem_resp #(.DEPTH(256), .WAIT(WAIT_P)) dut (
    .clk   (clk),
    .rst   (rst),
    .memrq (memrq),
    .memwq (memwq),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata),
    .ack   (ack),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rq;
    logic        wq;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } resp_t;

  resp_t sb[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected response
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = sb.pop_front();
        chk("ack_rdata", rdata, r.rd);
        chk("ack_err", {31'd0, err}, {31'd0, r.er});
      end
    end else begin
      chk("idle_rdata", rdata, 32'd0);
    end
  end

  // One transaction from IDLE; checks latency, leaves the DUT in IDLE
  task automatic xact(input vec_t v);
    int k;
    resp_t r;
    memrq = v.rq; memwq = v.wq; addr = v.a; wdata = v.wd; wstrb = v.ws;
    r.rd = v.exp_rd; r.er = v.exp_err;
    sb.push_back(r);
    @(posedge clk); #1;
    memrq = 1'b0; memwq = 1'b0;
    k = 1;
    while (ack !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, L);
    @(posedge clk); #1;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h20, 32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h20, 32'h0,        4'hF, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h10, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 32'h00FF00FF, 4'hA, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h10, 32'h0,        4'h0, 32'h00AD00EF, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'hFF, 32'h5A5AA5A5, 4'hF, 32'h0,        1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'hFF, 32'h0,        4'h0, 32'h5A5AA5A5, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 8'h30, 32'h12345678, 4'hF, 32'h0,        1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h30, 32'h0,        4'h0, 32'h12345678, 1'b0};

    rst = 1'b1; memrq = 1'b0; memwq = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  {31'd0, ack},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      xact(tbl[i]);
    end

    // Requests arriving while busy are ignored
    begin
      int k;
      resp_t r;
      memrq = 1'b1; addr = 8'h10;
      r.rd = 32'h00AD00EF; r.er = 1'b0;
      sb.push_back(r);
      @(posedge clk); #1;
      memrq = 1'b0; memwq = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF;
      k = 1;
      while (ack !== 1'b1 && k < 40) begin
        chk("busy_wait", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        k++;
      end
      chk("busy_resp", {31'd0, busy}, 32'd1);
      chk("busy_latency", k, L);
      memwq = 1'b0;
      @(posedge clk); #1;
      chk("busy_idle", {31'd0, busy}, 32'd0);
      xact('{1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 32'h00AD00EF, 1'b0});
    end

    // Reset while a write is in flight aborts it with no ack
    memwq = 1'b1; addr = 8'h30; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    @(posedge clk); #1;
    memwq = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_ack",   {31'd0, ack},  32'd0);
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    chk("abort_err",   {31'd0, err},  32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    memrq = 1'b1; addr = 8'h30;
    @(posedge clk); #1;
    chk("postrst_ignored", {31'd0, busy}, 32'd0);
    memrq = 1'b0;
    @(posedge clk); #1;
    xact('{1'b1, 1'b0, 8'h30, 32'h0, 4'h0, 32'h12345678, 1'b0});

    // Read request held high: re-accepted each IDLE, never back-to-back acks
    begin
      resp_t r;
      int nacc;
      nacc = (6 + L) / (L + 1);
      r.rd = 32'h11BB33DD; r.er = 1'b0;
      for (int j = 0; j < nacc; j++) sb.push_back(r);
      memrq = 1'b1; addr = 8'h20;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        chk("hold_ack",  {31'd0, ack},  {31'd0, (i % (L + 1)) == (L - 1)});
        chk("hold_busy", {31'd0, busy}, {31'd0, (i % (L + 1)) != L});
      end
      memrq = 1'b0;
      repeat (L + 2) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
